// File: rtl/proc_run_sequencer.sv
// Host-side sequencer for the single-cycle core: loads instruction/data memory,
// runs the core with a cycle budget, and reads results back, one response per command.
`timescale 1ns/1ps

module proc_run_sequencer #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              mem_sel,
  output logic              cpu_rst,
  input  logic              cpu_done,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [1:0] OP_LOAD_I = 2'b00;
  localparam logic [1:0] OP_LOAD_D = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_I,
    S_WR_D,
    S_RUN,
    S_RD,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic              phase_q, phase_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              mem_sel_q, mem_sel_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;

  // Next-state and next-output logic; phase_q splits WR/RD into a setup and an action cycle.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;
    dmem_we_d     = 1'b0;
    dmem_addr_d   = dmem_addr_q;
    dmem_wdata_d  = dmem_wdata_q;
    mem_sel_d     = mem_sel_q;
    cpu_rst_d     = cpu_rst_q;
    cycle_count_d = cycle_count_q;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          phase_d     = 1'b0;
          unique case (cmd_op)
            OP_LOAD_I: begin
              imem_addr_d  = cmd_addr;
              imem_wdata_d = cmd_wdata;
              state_d      = S_WR_I;
            end
            OP_LOAD_D: begin
              dmem_addr_d  = cmd_addr;
              dmem_wdata_d = cmd_wdata;
              state_d      = S_WR_D;
            end
            OP_RUN: begin
              cpu_rst_d     = 1'b0;
              mem_sel_d     = 1'b1;
              cycle_count_d = '0;
              state_d       = S_RUN;
            end
            OP_READ: begin
              dmem_addr_d = cmd_addr;
              state_d     = S_RD;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_WR_I: begin
        if (!phase_q) begin
          phase_d   = 1'b1;
          imem_we_d = 1'b1;
        end else begin
          phase_d      = 1'b0;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end
      end

      S_WR_D: begin
        if (!phase_q) begin
          phase_d   = 1'b1;
          dmem_we_d = 1'b1;
        end else begin
          phase_d      = 1'b0;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end
      end

      S_RD: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d      = 1'b0;
          rsp_data_d   = dmem_rdata;
          rsp_status_d = ST_OK;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end
      end

      // Done has priority over the budget check in the same cycle.
      S_RUN: begin
        if (cpu_done) begin
          rsp_data_d   = DATA_W'(cycle_count_q);
          rsp_status_d = ST_OK;
          rsp_valid_d  = 1'b1;
          cpu_rst_d    = 1'b1;
          mem_sel_d    = 1'b0;
          state_d      = S_RESP;
        end else if (cycle_count_q == CNT_LAST) begin
          rsp_data_d   = TIMEOUT_DATA;
          rsp_status_d = ST_TIMEOUT;
          rsp_valid_d  = 1'b1;
          cpu_rst_d    = 1'b1;
          mem_sel_d    = 1'b0;
          state_d      = S_RESP;
        end else begin
          cycle_count_d = cycle_count_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        cpu_rst_d   = 1'b1;
        mem_sel_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_status_q  <= ST_OK;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      mem_sel_q     <= 1'b0;
      cpu_rst_q     <= 1'b1;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
      dmem_we_q     <= dmem_we_d;
      dmem_addr_q   <= dmem_addr_d;
      dmem_wdata_q  <= dmem_wdata_d;
      mem_sel_q     <= mem_sel_d;
      cpu_rst_q     <= cpu_rst_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign mem_sel     = mem_sel_q;
  assign cpu_rst     = cpu_rst_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_proc_run_sequencer.sv
// Scoreboarded bench for proc_run_sequencer: directed load/read/run/timeout/backpressure/reset cases.
`timescale 1ns/1ps

module tb_proc_run_sequencer;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_status;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              mem_sel;
  logic              cpu_rst;
  logic              cpu_done;
  logic [CNT_W-1:0]  cycle_count;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        status;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   low_cnt = 0;
  int   run_cyc = 0;
  int   done_at = 0;
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  proc_run_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .mem_sel(mem_sel), .cpu_rst(cpu_rst), .cpu_done(cpu_done), .cycle_count(cycle_count)
  );

  // Data memory model with asynchronous read.
  always @(posedge clk) if (dmem_we) ram[dmem_addr] <= dmem_wdata;
  assign dmem_rdata = ram[dmem_addr];

  // Core model: halts on RUN cycle done_at (1-based), never when done_at is 0.
  always @(posedge clk) begin
    if (cpu_rst) run_cyc <= 0;
    else         run_cyc <= run_cyc + 1;
  end
  assign cpu_done = (done_at != 0) && !cpu_rst && (run_cyc == done_at - 1);

  // Monitor: response scoreboard plus per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (!cpu_rst) low_cnt++;
      n_cmp++;
      if (mem_sel !== !cpu_rst) begin
        n_err++;
        $display("FAIL mem_sel_mirror: mem_sel=%b cpu_rst=%b, required mem_sel=~cpu_rst", mem_sel, cpu_rst);
      end
      n_cmp++;
      if ((imem_we && dmem_we) || (dmem_we && mem_sel)) begin
        n_err++;
        $display("FAIL strobe_excl: imem_we=%b dmem_we=%b mem_sel=%b", imem_we, dmem_we, mem_sel);
      end
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected: got data=%h status=%b, required no response", rsp_data, rsp_status);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          if (rsp_data !== e.data || rsp_status !== e.status) begin
            n_err++;
            $display("FAIL rsp: got data=%h status=%b, required data=%h status=%b",
                     rsp_data, rsp_status, e.data, e.status);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_rsp(input logic [DATA_W-1:0] d, input logic [1:0] s);
    rsp_t e;
    e.data   = d;
    e.status = s;
    exp_q.push_back(e);
  endtask

  // Issue one command; returns 1 ns after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_ready_timeout: got 0, required 1");
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d responses pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_case(input string name, input int halt_at, input logic [DATA_W-1:0] rd,
                          input logic [1:0] rs, input int low_req);
    int start;
    done_at = halt_at;
    start   = low_cnt;
    expect_rsp(rd, rs);
    send(2'b10, '0, '0);
    drain(name);
    chk({name, "_low_cycles"}, DATA_W'(low_cnt - start), DATA_W'(low_req));
    chk({name, "_cpu_rst"}, DATA_W'(cpu_rst), 32'd1);
    chk({name, "_mem_sel"}, DATA_W'(mem_sel), 32'd0);
    chk({name, "_cycle_count"}, cycle_count, rd == DATA_W'(TIMEOUT) ? DATA_W'(TIMEOUT - 1) : rd);
    done_at = 0;
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_cpu_rst", DATA_W'(cpu_rst), 32'd1);
    chk("rst_cmd_ready", DATA_W'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", DATA_W'(rsp_valid), 32'd0);
    chk("rst_strobes", DATA_W'({imem_we, dmem_we, mem_sel}), 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_rsp", DATA_W'({rsp_data, rsp_status}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Load data: one-cycle strobe, response two edges after accept.
    expect_rsp('0, 2'b00);
    send(2'b01, 10'd5, 32'hDEADBEEF);
    chk("ld_d_e0_we", DATA_W'(dmem_we), 32'd0);
    chk("ld_d_e0_rv", DATA_W'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("ld_d_e1_we", DATA_W'(dmem_we), 32'd1);
    chk("ld_d_e1_addr", DATA_W'(dmem_addr), 32'd5);
    chk("ld_d_e1_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("ld_d_e1_rv", DATA_W'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("ld_d_e2_we", DATA_W'(dmem_we), 32'd0);
    chk("ld_d_e2_rv", DATA_W'(rsp_valid), 32'd1);
    drain("ld_d");

    // Load instruction at the top address.
    expect_rsp('0, 2'b00);
    send(2'b00, 10'h3FF, 32'h0000_0013);
    @(posedge clk); #1;
    chk("ld_i_we", DATA_W'({imem_we, dmem_we}), 32'd2);
    chk("ld_i_addr", DATA_W'(imem_addr), 32'h3FF);
    chk("ld_i_wdata", imem_wdata, 32'h0000_0013);
    @(posedge clk); #1;
    chk("ld_i_we_drop", DATA_W'(imem_we), 32'd0);
    drain("ld_i");

    // Second data word at the top address, then read both back.
    expect_rsp('0, 2'b00);
    send(2'b01, 10'h3FF, 32'h1234_5678);
    drain("ld_d2");
    expect_rsp(32'hDEADBEEF, 2'b00);
    send(2'b11, 10'd5, 32'hFFFF_FFFF);
    chk("rd_e0_rv", DATA_W'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rd_e1_rv", DATA_W'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rd_e2_rv", DATA_W'(rsp_valid), 32'd1);
    drain("rd5");
    expect_rsp(32'h1234_5678, 2'b00);
    send(2'b11, 10'h3FF, '0);
    drain("rd3ff");

    run_case("run_done3", 3, 32'd2, 2'b00, 3);
    run_case("run_done1", 1, 32'd0, 2'b00, 1);
    run_case("run_timeout", 0, DATA_W'(TIMEOUT), 2'b01, 16);
    run_case("run_boundary", 16, 32'd15, 2'b00, 16);

    // Backpressure: response held stable, extra commands ignored.
    rsp_ready = 1'b0;
    expect_rsp(32'hDEADBEEF, 2'b00);
    send(2'b11, 10'd5, '0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", DATA_W'(rsp_valid), 32'd1);
      chk("bp_rsp_data", rsp_data, 32'hDEADBEEF);
      chk("bp_rsp_status", DATA_W'(rsp_status), 32'd0);
      chk("bp_cmd_ready", DATA_W'(cmd_ready), 32'd0);
      cmd_valid = (i == 3 || i == 6);
      cmd_op = 2'b01; cmd_addr = 10'd5; cmd_wdata = 32'h0;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain("bp");
    chk("bp_ram_intact", ram[5], 32'hDEADBEEF);

    // Reset during RUN: immediate safe state, no response.
    done_at = 0;
    send(2'b10, '0, '0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rr_cpu_rst", DATA_W'(cpu_rst), 32'd1);
    chk("rr_cmd_ready", DATA_W'(cmd_ready), 32'd1);
    chk("rr_rsp_valid", DATA_W'(rsp_valid), 32'd0);
    chk("rr_strobes", DATA_W'({imem_we, dmem_we, mem_sel}), 32'd0);
    chk("rr_cycle_count", cycle_count, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rr_no_rsp", DATA_W'(rsp_valid), 32'd0);
    expect_rsp(32'hDEADBEEF, 2'b00);
    send(2'b11, 10'd5, '0);
    drain("rr_rd");

    chk("final_queue_empty", DATA_W'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_run_sequencer.md
Name: proc_run_sequencer

Overview:
Host-facing controller that sequences the single-cycle processor through load, run and readback phases. It writes program words into instruction memory and operands into data memory, then holds the core in reset and releases it. It counts execution cycles until the core signals done or a timeout expires, and reads result words back out of data memory. Each host command is accepted through a valid/ready handshake and answered with exactly one response.

Parameters:
ADDR_W, 10, word-address width of instruction and data memories
DATA_W, 32, memory word width
TIMEOUT, 4096, max RUN cycles before abort (1 .. 2^CNT_W-1)
CNT_W, 32, cycle counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 load-instr, 01 load-data, 10 run, 11 read-data
cmd_addr  in  ADDR_W  word address (ignored for run)
cmd_wdata  in  DATA_W  write data (loads only)
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_data  out  DATA_W  read data / cycle count / 0
rsp_status  out  2  00 OK, 01 TIMEOUT, others reserved (never driven)
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  instruction memory write address
imem_wdata  out  DATA_W  instruction memory write data
dmem_we  out  1  data memory write strobe
dmem_addr  out  ADDR_W  data memory address (write and async read)
dmem_wdata  out  DATA_W  data memory write data
dmem_rdata  in  DATA_W  data memory asynchronous read data
mem_sel  out  1  1 = core owns data-memory port, 0 = controller owns it
cpu_rst  out  1  core reset; high = core held
cpu_done  in  1  core halt indication (combinational from decode)
cycle_count  out  CNT_W  live RUN cycle counter

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; cpu_rst=1; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_status=00; imem_we=0; dmem_we=0; mem_sel=0; cycle_count=0; addresses and wdata=0.
- Reset mid-operation: any pending response or write is dropped and the reset values apply immediately (asynchronous).
- States: IDLE, WR_I, WR_D, RUN, RD, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr and wdata, drop cmd_ready, then go to:
  - WR_I for op 00,
  - WR_D for op 01,
  - RUN for op 10,
  - RD for op 11.
- cmd_ready=1 only in IDLE. The controller holds at most one command in flight.
- WR_I / WR_D:
  - Exactly one cycle with imem_we=1 (or dmem_we=1) and the latched addr/data.
  - Strobe drops next cycle. Go to RESP with rsp_data=0, status 00.
- RD:
  - dmem_addr is driven for one cycle.
  - dmem_rdata is captured at the end of that cycle into rsp_data with status 00, then go to RESP.
- Latency from accept edge to rsp_valid edge: load = 2 cycles, read = 2 cycles.
- RUN:
  - On the entry edge, cpu_rst=0, mem_sel=1, cycle_count=0.
  - In each RUN cycle, sample cpu_done.
  - If cpu_done=1: rsp_data = cycle_count, status 00, go to RESP.
  - Else if cycle_count == TIMEOUT-1: rsp_data = TIMEOUT, status 01, go to RESP.
  - Else cycle_count++.
  - A program whose instruction 0 is the halt returns count 0.
  - cpu_done and the timeout condition in the same cycle: done wins and status is 00.
  - On leaving RUN, cpu_rst=1 and mem_sel=0 on the same edge.
  - cycle_count holds its final value until the next RUN entry.
- cpu_done is ignored outside RUN.
- RESP:
  - rsp_valid=1, with rsp_data and rsp_status stable until rsp_valid&&rsp_ready.
  - On that handshake edge: rsp_valid=0, state IDLE, cmd_ready=1.
  - A new command can therefore be accepted one cycle after the response handshake.
- imem_we and dmem_we are never both high. dmem_we is never high while mem_sel=1.
- Address arithmetic is none. The top level applies no wrap; addresses are passed through at width ADDR_W.

Test Plan:
- Reset: assert rst mid-cycle -> immediately cpu_rst=1, cmd_ready=1, rsp_valid=0, all strobes 0, mem_sel=0.
- Load/readback:
  - Load-data addr 5 data 0xDEADBEEF -> dmem_we pulses exactly 1 cycle with addr 5 and data DEADBEEF; response 0/OK 2 cycles after accept.
  - Read-data addr 5 with a bench RAM model -> rsp_data 0xDEADBEEF, status 00.
- Run normal: bench raises cpu_done on the 3rd RUN cycle -> rsp_data=2, status 00, cpu_rst low for exactly 3 cycles, mem_sel mirrors it.
- Timeout: TIMEOUT=16, cpu_done held 0 -> cpu_rst low for exactly 16 cycles; rsp_data=16, status 01, cpu_rst=1 afterwards.
- Boundary: TIMEOUT=16 with cpu_done rising in the 16th RUN cycle -> status 00, rsp_data=15.
- Backpressure and reset during run:
  - Hold rsp_ready=0 for 10 cycles -> rsp_valid, data and status stable; cmd_ready stays 0; cmd_valid pulses are ignored.
  - Assert rst during RUN -> cpu_rst=1 asynchronously, no response is issued, and a new command is accepted after release.
